regfile_write_arbiter: RTL and testbench

- Owns the single write port (writeReg/writeData/regWrite) of the 32x32 register file.
- After reset, sequences a clear sweep that writes zero to every register.
- Then shares the write port between two writeback requesters: A (ALU writeback) and B (load writeback).
- Uses valid/ready handshakes and round-robin arbitration; drives a registered write port with one-cycle latency.

---
 rtl/regfile_write_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Owns the single write port of the register file. After reset it clears
//   every register with a zero-write sweep. It then shares the port between
//   two writeback requesters (A = ALU, B = load) using valid/ready handshakes
//   and round-robin arbitration. The write port is registered, so a transfer
//   accepted in cycle N writes the register file on edge N+1.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   INIT  | clear sweep: one zero-write per cycle to index init_cnt
//   RUN   | arbitrate A/B; winner's reg/data drive the port on next edge
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   a_valid/a_reg/a_data  requester A write request
//   a_ready               A accepted this cycle (combinational)
//   b_valid/b_reg/b_data  requester B write request
//   b_ready               B accepted this cycle (combinational)
//   writeReg/writeData    register file write index/data (registered)
//   regWrite              register file write enable (registered)
//   init_done             clear sweep complete (registered, sticky)
//   last_grant            most recent accepted requester, 0=A 1=B (registered)
module regfile_write_arbiter #(
  parameter int NUM_REGS         = 32,
  parameter int ADDR_W           = 5,
  parameter int DATA_W           = 32,
  parameter int ZERO_REG_DISCARD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              regWrite,
  output logic              init_done,
  output logic              last_grant
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] init_cnt;
  logic              rr_ptr;
  logic              sweep_last;
  logic              grant_a;
  logic              grant_b;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic              sel_discard;

  assign sweep_last = (init_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    case (state)
      INIT: begin
        if (sweep_last) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (a_valid && b_valid) begin
          // rr_ptr names the requester favoured on a tie.
          grant_a = ~rr_ptr;
          grant_b = rr_ptr;
        end else begin
          grant_a = a_valid;
          grant_b = b_valid;
        end
      end
      default: state_next = INIT;
    endcase
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  assign sel_reg     = grant_b ? b_reg  : a_reg;
  assign sel_data    = grant_b ? b_data : a_data;
  // A write to register 0 is still handshaken so the requester can move on.
  assign sel_discard = (ZERO_REG_DISCARD != 0) && (sel_reg == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_cnt   <= '0;
      rr_ptr     <= 1'b0;
      writeReg   <= '0;
      writeData  <= '0;
      regWrite   <= 1'b0;
      init_done  <= 1'b0;
      last_grant <= 1'b0;
    end else if (state == INIT) begin
      writeReg  <= init_cnt;
      writeData <= '0;
      regWrite  <= 1'b1;
      init_cnt  <= init_cnt + ADDR_W'(1);
    end else begin
      init_done <= 1'b1;
      if (grant_a || grant_b) begin
        writeReg   <= sel_reg;
        writeData  <= sel_data;
        regWrite   <= ~sel_discard;
        last_grant <= grant_b;
        rr_ptr     <= ~grant_b;
      end else begin
        regWrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_reg = '0, b_reg = '0;
  logic [31:0] a_data = '0, b_data = '0;

  logic        a_ready, b_ready, regWrite, init_done, last_grant;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        a_ready0, b_ready0, regWrite0, init_done0, last_grant0;
  logic [4:0]  writeReg0;
  logic [31:0] writeData0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .ZERO_REG_DISCARD(1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
    .init_done(init_done), .last_grant(last_grant)
  );

  regfile_write_arbiter #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .ZERO_REG_DISCARD(0)) dut_keep0 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready0),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready0),
    .writeReg(writeReg0), .writeData(writeData0), .regWrite(regWrite0),
    .init_done(init_done0), .last_grant(last_grant0)
  );

  // Reference model: sweep position, who is owed the next tie, and the
  // values the write port should show after the most recent edge.
  bit          m_init;
  int          m_idx;
  bit          m_owed_b;
  bit          e_we, e_we0, e_done, e_lg;
  logic [4:0]  e_reg;
  logic [31:0] e_data;
  logic [31:0] issued[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init   = 1'b1;
    m_idx    = 0;
    m_owed_b = 1'b0;
    e_we = 0; e_we0 = 0; e_done = 0; e_lg = 0; e_reg = '0; e_data = '0;
  endtask

  task automatic check_port();
    check("regWrite",   32'(regWrite),   32'(e_we));
    check("writeReg",   32'(writeReg),   32'(e_reg));
    check("writeData",  writeData,       e_data);
    check("init_done",  32'(init_done),  32'(e_done));
    check("last_grant", 32'(last_grant), 32'(e_lg));
    check("regWrite_k0",  32'(regWrite0),  32'(e_we0));
    check("writeReg_k0",  32'(writeReg0),  32'(e_reg));
    check("writeData_k0", writeData0,      e_data);
    check("init_done_k0", 32'(init_done0), 32'(e_done));
  endtask

  // Hold reset low across one rising edge, checking the immediate reset
  // values, then release away from any edge.
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    model_reset();
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check_port();
    @(posedge clk);
    #1;
    check_port();
    rst = 1'b1;
  endtask

  task automatic cycle(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit bv, input logic [4:0] br, input logic [31:0] bd,
                       output bit ga, output bit gb);
    @(negedge clk);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    #1;
    ga = !m_init && av && (!bv || !m_owed_b);
    gb = !m_init && bv && (!av || m_owed_b);
    check("a_ready", 32'(a_ready), 32'(ga));
    check("b_ready", 32'(b_ready), 32'(gb));
    check("a_ready_k0", 32'(a_ready0), 32'(ga));
    check("b_ready_k0", 32'(b_ready0), 32'(gb));
    if (m_init) begin
      e_reg = 5'(m_idx); e_data = '0; e_we = 1; e_we0 = 1;
      m_idx++;
      if (m_idx == 32) m_init = 0;
    end else begin
      e_done = 1;
      if (ga || gb) begin
        e_reg  = gb ? br : ar;
        e_data = gb ? bd : ad;
        e_we0  = 1;
        e_we   = (e_reg != 0);
        e_lg   = gb;
        m_owed_b = !gb;
        issued.push_back(e_data);
      end else begin
        e_we = 0; e_we0 = 0;
      end
    end
    @(posedge clk);
    #1;
    check_port();
  endtask

  task automatic idle(input int n);
    bit ga, gb;
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0, ga, gb);
  endtask

  initial begin
    bit ga, gb;
    bit pa, pb;
    logic [4:0]  par, pbr;
    logic [31:0] pad, pbd;
    int ad, bd, guard;

    model_reset();
    #1;
    check("por_a_ready", 32'(a_ready), 32'd0);
    check_port();
    pulse_reset();

    // Full clear sweep plus the init_done edge.
    idle(34);
    check("sweep_done", 32'(init_done), 32'd1);

    // Single A write.
    cycle(1, 5'd5, 32'hDEADBEEF, 0, '0, '0, ga, gb);
    check("single_grant", 32'(ga), 32'd1);
    check("single_reg", 32'(writeReg), 32'd5);
    check("single_data", writeData, 32'hDEADBEEF);
    idle(1);
    check("single_we_drop", 32'(regWrite), 32'd0);

    // B alone so that A is owed the next tie, then continuous contention.
    cycle(0, '0, '0, 1, 5'd1, 32'h55, ga, gb);
    issued.delete();
    ad = 1; bd = 100;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 5'd3, 32'(ad), 1, 5'd4, 32'(bd), ga, gb);
      check("alt_we", 32'(regWrite), 32'd1);
      if (ga) ad++;
      if (gb) bd++;
    end
    for (int i = 0; i < 8; i++)
      check("alt_seq", issued[i], (i % 2 == 0) ? 32'(1 + i/2) : 32'(100 + i/2));
    idle(1);

    // Write to register 0: discarded on one instance, issued on the other.
    cycle(1, 5'd0, 32'd7, 0, '0, '0, ga, gb);
    check("zero_discard", 32'(regWrite), 32'd0);
    check("zero_keep", 32'(regWrite0), 32'd1);
    check("zero_keep_data", writeData0, 32'd7);

    // A served last so B is owed the tie; same destination from both.
    cycle(1, 5'd2, 32'd1, 0, '0, '0, ga, gb);
    issued.delete();
    cycle(1, 5'd9, 32'd11, 1, 5'd9, 32'd22, ga, gb);
    check("same_first_b", 32'(gb), 32'd1);
    cycle(1, 5'd9, 32'd11, 0, '0, '0, ga, gb);
    check("same_final_reg", 32'(writeReg), 32'd9);
    check("same_final_data", writeData, 32'd11);
    check("same_order", issued[0], 32'd22);
    idle(1);

    // Reset mid-sweep after index 17 has been issued.
    pulse_reset();
    guard = 0;
    while (m_idx < 18 && guard < 40) begin
      idle(1);
      guard++;
    end
    check("mid_idx", 32'(writeReg), 32'd17);
    pulse_reset();
    idle(32);
    check("restart_not_done", 32'(init_done), 32'd0);
    idle(1);
    check("restart_done", 32'(init_done), 32'd1);

    // Randomised traffic from compliant requesters.
    pa = 0; pb = 0; par = '0; pbr = '0; pad = '0; pbd = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pa && ($urandom_range(2) != 0)) begin
        pa = 1; par = 5'($urandom_range(31)); pad = $urandom;
        if ($urandom_range(7) == 0) par = '0;
      end
      if (!pb && ($urandom_range(2) != 0)) begin
        pb = 1; pbr = 5'($urandom_range(31)); pbd = $urandom;
        if ($urandom_range(7) == 0) pbr = '0;
      end
      cycle(pa, par, pad, pb, pbr, pbd, ga, gb);
      if (ga) pa = 0;
      if (gb) pb = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
